if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, driving the decode stage over the fs→ds handshake.
- Holds the pre-IF next-PC logic and the fs-stage register.
- Drives the synchronous instruction SRAM.
- Consumes br_bus from decode. Produces fs_to_ds_valid and fs_to_ds_bus = {inst, pc}.
- Implements MIPS delay-slot semantics: a branch resolved in ds redirects the fetch after the slot instruction currently in fs.

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/if_stage_fs_inst_buf.sv | 31 +++
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants and bus layouts for the MIPS pipeline.
// Build option FS_ADEF_CHK_EN widens the fs->ds bus by one adef bit.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'hBFC00000;
  localparam int          BR_BUS_WD = 33;

`ifdef FS_ADEF_CHK_EN
  localparam int FS_TO_DS_BUS_WD = 65;
`else
  localparam int FS_TO_DS_BUS_WD = 64;
`endif

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  function automatic logic [31:0] seqPcOf(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_fs_inst_buf.sv
// Holds the SRAM word for an instruction stalled in fs, since the SRAM
// only presents its data for one cycle after the request.
module if_stage_fs_inst_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_capture,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_valid
);

  logic [31:0] r_data;
  logic        r_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data  <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: pre-IF next-PC selection, fs register, SRAM drive.
// Define FS_ADEF_CHK_EN to flag misaligned PCs and suppress their fetch.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  logic        r_toFsValid;
  logic        r_fsValid;
  logic [31:0] r_fsPc;
  logic        r_brPend;
  logic [31:0] r_brPendTarget;

  br_bus_t     w_br;
  logic [31:0] w_seqPc;
  logic [31:0] w_nextPc;
  logic        w_fsReadyGo;
  logic        w_fsAllowin;
  logic        w_advance;
  logic        w_handshake;
  logic        w_capture;
  logic        w_bufValid;
  logic [31:0] w_bufInst;
  logic [31:0] w_rawInst;
  logic [31:0] w_fsInst;

  assign w_br = br_bus;

  // Registered copy of reset so the first cycle after release issues no fetch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_toFsValid <= 1'b0;
    else         r_toFsValid <= 1'b1;
  end

  assign w_seqPc  = seqPcOf(r_fsPc);
  assign w_nextPc = w_br.taken ? w_br.target :
                    r_brPend   ? r_brPendTarget : w_seqPc;

  assign w_fsReadyGo    = 1'b1;
  assign w_fsAllowin    = !r_fsValid || (w_fsReadyGo && ds_allowin);
  assign w_advance      = r_toFsValid && w_fsAllowin;
  assign fs_to_ds_valid = r_fsValid && w_fsReadyGo;
  assign w_handshake    = fs_to_ds_valid && ds_allowin;

  // fs_pc resets one word early so the first sequential fetch lands on RESET_PC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fsValid <= 1'b0;
      r_fsPc    <= RESET_PC - 32'd4;
    end else begin
      if (w_fsAllowin) r_fsValid <= r_toFsValid;
      if (w_advance)   r_fsPc    <= w_nextPc;
    end
  end

  // A redirect that arrives while fetch is blocked must survive until it issues.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_brPend       <= 1'b0;
      r_brPendTarget <= 32'h0;
    end else if (w_advance) begin
      r_brPend       <= 1'b0;
    end else if (w_br.taken) begin
      r_brPend       <= 1'b1;
      r_brPendTarget <= w_br.target;
    end
  end

  assign w_capture = r_fsValid && !ds_allowin && !w_bufValid;

  if_stage_fs_inst_buf u_instBuf (
    .clk       (clk),
    .resetn    (resetn),
    .i_capture (w_capture),
    .i_clear   (w_handshake),
    .i_data    (inst_sram_rdata),
    .o_data    (w_bufInst),
    .o_valid   (w_bufValid)
  );

  assign w_rawInst = w_bufValid ? w_bufInst : inst_sram_rdata;

`ifdef FS_ADEF_CHK_EN
  logic w_fsAdef;
  logic w_nextMisaligned;

  assign w_nextMisaligned = (w_nextPc[1:0] != 2'b00);
  assign w_fsAdef         = r_fsValid && (r_fsPc[1:0] != 2'b00);
  assign inst_sram_en     = w_advance && !w_nextMisaligned;
  assign w_fsInst         = w_fsAdef ? 32'h0 : w_rawInst;
  assign fs_to_ds_bus     = {w_fsAdef, w_fsInst, r_fsPc};
`else
  assign inst_sram_en     = w_advance;
  assign w_fsInst         = w_rawInst;
  assign fs_to_ds_bus     = {w_fsInst, r_fsPc};
`endif

  assign inst_sram_addr  = w_nextPc;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, stall/buffer, branch, pending branch,
// PC wrap and asynchronous reset, with a one-cycle-latency SRAM model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic                       clk;
  logic                       resetn;
  logic                       dsAllowin;
  logic [BR_BUS_WD-1:0]       brBus;
  logic                       fsToDsValid;
  logic [FS_TO_DS_BUS_WD-1:0] fsToDsBus;
  logic                       instSramEn;
  logic [3:0]                 instSramWen;
  logic [31:0]                instSramAddr;
  logic [31:0]                instSramWdata;
  logic [31:0]                instSramRdata;

  logic [31:0] sramData;
  logic        corrupt;
  int          checkCount;
  int          passCount;

  if_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_allowin      (dsAllowin),
    .br_bus          (brBus),
    .fs_to_ds_valid  (fsToDsValid),
    .fs_to_ds_bus    (fsToDsBus),
    .inst_sram_en    (instSramEn),
    .inst_sram_wen   (instSramWen),
    .inst_sram_addr  (instSramAddr),
    .inst_sram_wdata (instSramWdata),
    .inst_sram_rdata (instSramRdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [64:0] busOf(input logic [31:0] pc);
    return {1'b0, instOf(pc), pc};
  endfunction

  // Synchronous SRAM: data for the address requested at the previous edge.
  always @(posedge clk) begin
    if (instSramEn) sramData <= instOf(instSramAddr);
  end
  assign instSramRdata = corrupt ? 32'hDEADBEEF : sramData;

  task automatic applyStimulus(input logic allow, input logic taken, input logic [31:0] target);
    dsAllowin = allow;
    brBus     = {taken, target};
  endtask

  task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    clk        = 1'b0;
    resetn     = 1'b0;
    corrupt    = 1'b0;
    sramData   = 32'h0;
    checkCount = 0;
    passCount  = 0;
    applyStimulus(1'b1, 1'b0, 32'h0);

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 65'(fsToDsValid), 65'd0);
    checkOutput("rst_en", 65'(instSramEn), 65'd0);
    checkOutput("rst_wen_wdata", {29'd0, instSramWen, instSramWdata}, 65'd0);
    resetn = 1'b1;
    #1;
    checkOutput("release_en_first_cycle", 65'(instSramEn), 65'd0);

    @(negedge clk);
    checkOutput("fetch0_en", 65'(instSramEn), 65'd1);
    checkOutput("fetch0_addr", 65'(instSramAddr), 65'(32'hBFC00000));
    checkOutput("fetch0_valid_low", 65'(fsToDsValid), 65'd0);

    @(negedge clk);
    checkOutput("fs0_valid", 65'(fsToDsValid), 65'd1);
    checkOutput("fs0_bus", 65'(fsToDsBus), busOf(32'hBFC00000));
    checkOutput("fetch1_addr", 65'(instSramAddr), 65'(32'hBFC00004));

    @(negedge clk);
    checkOutput("fs1_bus", 65'(fsToDsBus), busOf(32'hBFC00004));
    checkOutput("fetch2_addr", 65'(instSramAddr), 65'(32'hBFC00008));
    applyStimulus(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("stall_en_0", 65'(instSramEn), 65'd0);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      corrupt = 1'b1;
      #1;
      checkOutput("stall_bus", 65'(fsToDsBus), busOf(32'hBFC00004));
      checkOutput("stall_en", 65'(instSramEn), 65'd0);
      checkOutput("stall_valid", 65'(fsToDsValid), 65'd1);
    end

    @(negedge clk);
    checkOutput("stall_end_bus", 65'(fsToDsBus), busOf(32'hBFC00004));
    applyStimulus(1'b1, 1'b0, 32'h0);
    corrupt = 1'b0;
    #1;
    checkOutput("resume_en", 65'(instSramEn), 65'd1);
    checkOutput("resume_addr", 65'(instSramAddr), 65'(32'hBFC00008));

    @(negedge clk);
    checkOutput("slot_bus", 65'(fsToDsBus), busOf(32'hBFC00008));
    checkOutput("slot_valid", 65'(fsToDsValid), 65'd1);
    applyStimulus(1'b1, 1'b1, 32'hBFC00100);
    #1;
    checkOutput("br_addr", 65'(instSramAddr), 65'(32'hBFC00100));
    checkOutput("br_en", 65'(instSramEn), 65'd1);

    @(negedge clk);
    checkOutput("br_target_bus", 65'(fsToDsBus), busOf(32'hBFC00100));
    applyStimulus(1'b0, 1'b1, 32'hBFC00200);
    #1;
    checkOutput("brstall_en", 65'(instSramEn), 65'd0);

    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("brpend_en", 65'(instSramEn), 65'd0);
    checkOutput("brpend_addr", 65'(instSramAddr), 65'(32'hBFC00200));
    checkOutput("brpend_bus", 65'(fsToDsBus), busOf(32'hBFC00100));
    applyStimulus(1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("brpend_issue_en", 65'(instSramEn), 65'd1);
    checkOutput("brpend_issue_addr", 65'(instSramAddr), 65'(32'hBFC00200));

    @(negedge clk);
    checkOutput("brpend_target_bus", 65'(fsToDsBus), busOf(32'hBFC00200));
    checkOutput("brpend_cleared_addr", 65'(instSramAddr), 65'(32'hBFC00204));
    applyStimulus(1'b1, 1'b1, 32'hFFFFFFFC);

    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("wrap_top_bus", 65'(fsToDsBus), busOf(32'hFFFFFFFC));
    checkOutput("wrap_seq_addr", 65'(instSramAddr), 65'(32'h0));

    @(negedge clk);
    checkOutput("wrap_zero_bus", 65'(fsToDsBus), busOf(32'h0));
    applyStimulus(1'b0, 1'b0, 32'h0);

    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_valid", 65'(fsToDsValid), 65'd0);
    checkOutput("async_rst_en", 65'(instSramEn), 65'd0);
    checkOutput("async_rst_addr", 65'(instSramAddr), 65'(32'hBFC00000));

    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rerun_addr", 65'(instSramAddr), 65'(32'hBFC00000));
    @(negedge clk);
    checkOutput("rerun_bus_no_stale_buf", 65'(fsToDsBus), busOf(32'hBFC00000));

`ifdef FS_ADEF_CHK_EN
    applyStimulus(1'b1, 1'b1, 32'hBFC00102);
    #1;
    checkOutput("adef_no_fetch", 65'(instSramEn), 65'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("adef_bus", 65'(fsToDsBus), {1'b1, 32'h0, 32'hBFC00102});
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
